// File: rtl/cobertura_motor_if.sv
// Signal bundle between the cover controller / sensors and the motor contactor stage.
interface cobertura_motor_if;
  logic       A;
  logic       F;
  logic       Fd;
  logic       Fe;
  logic       ack_fault;
  logic       motor_open;
  logic       motor_close;
  logic       busy;
  logic       fault;
  logic [2:0] state;

  modport master (
    output A, F, Fd, Fe, ack_fault,
    input  motor_open, motor_close, busy, fault, state
  );

  modport slave (
    input  A, F, Fd, Fe, ack_fault,
    output motor_open, motor_close, busy, fault, state
  );
endinterface

// File: rtl/cobertura_motor.sv
// Greenhouse cover motor driver: dead time before every start, direction
// interlock, travel timeout and a latched sensor/timeout fault.
module cobertura_motor #(
  parameter int DEAD_TIME = 4,
  parameter int TIMEOUT   = 200,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  cobertura_motor_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAD    = 3'd1,
    OPENING = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_open_q, target_open_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      target_open_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_open_q <= target_open_d;
    end
  end

  // Both limit switches active is physically impossible, so it overrides every state but FAULT.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_open_d = target_open_q;
    if (state_q != FAULT && bus.Fd && bus.Fe) begin
      state_d = FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.A && !bus.F && !bus.Fd) begin
            state_d       = DEAD;
            target_open_d = 1'b1;
            cnt_d         = '0;
          end else if (bus.F && !bus.A && !bus.Fe) begin
            state_d       = DEAD;
            target_open_d = 1'b0;
            cnt_d         = '0;
          end
        end
        DEAD: begin
          if (target_open_q ? !bus.A : !bus.F) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEAD_LAST) begin
            state_d = target_open_q ? OPENING : CLOSING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        OPENING: begin
          if (bus.Fd) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = FAULT;
            cnt_d   = '0;
          end else if (!bus.A && bus.F) begin
            state_d       = DEAD;
            target_open_d = 1'b0;
            cnt_d         = '0;
          end else if (!bus.A) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CLOSING: begin
          if (bus.Fe) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = FAULT;
            cnt_d   = '0;
          end else if (!bus.F && bus.A) begin
            state_d       = DEAD;
            target_open_d = 1'b1;
            cnt_d         = '0;
          end else if (!bus.F) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FAULT: begin
          if (bus.ack_fault && !bus.A && !bus.F && !(bus.Fd && bus.Fe)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = FAULT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.motor_open  = (state_q == OPENING);
  assign bus.motor_close = (state_q == CLOSING);
  assign bus.busy        = (state_q == DEAD) || (state_q == OPENING) || (state_q == CLOSING);
  assign bus.fault       = (state_q == FAULT);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_cobertura_motor.sv
// Scoreboard bench for cobertura_motor with DEAD_TIME=4, TIMEOUT=20.
module tb_cobertura_motor;

  typedef struct packed {
    logic       rst;
    logic       a;
    logic       f;
    logic       fd;
    logic       fe;
    logic       ack;
    logic [2:0] st;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [6:0] exp_q[$];
  logic [6:0] got, exp_v;

  cobertura_motor_if ifc ();

  cobertura_motor #(.DEAD_TIME(4), .TIMEOUT(20), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  // Contactor interlock watched on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (ifc.motor_open === 1'b1 && ifc.motor_close === 1'b1) begin
        n_bad++;
        $display("[TB] FAIL interlock: motor_open=%b motor_close=%b, required not both 1",
                 ifc.motor_open, ifc.motor_close);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, a, f, fd, fe, ack, input logic [2:0] st);
    vec_t v;
    v.rst = r; v.a = a; v.f = f; v.fd = fd; v.fe = fe; v.ack = ack; v.st = st;
    return v;
  endfunction

  // Expected {state, motor_open, motor_close, busy, fault} for a state code.
  function automatic logic [6:0] model(input logic [2:0] st);
    return {st, st == 3'd2, st == 3'd3, (st >= 3'd1 && st <= 3'd3), st == 3'd4};
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst           = v.rst;
    ifc.A         = v.a;
    ifc.F         = v.f;
    ifc.Fd        = v.fd;
    ifc.Fe        = v.fe;
    ifc.ack_fault = v.ack;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(model(3'd0));
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
    got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL reset: got %b required %b", got, exp_v);
    end
  endtask

  task automatic test_open_limit();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    for (int i = 4; i < 10; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 2));
    v.push_back(mk(0, 1, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(model(v[i].st));
      applyStimulus(v[i]);
      got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL open_limit edge %0d: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    for (int i = 4; i < 24; i++) v.push_back(mk(0, 0, 1, 0, 0, 0, 3));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 4));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 4));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 4));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 4));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(model(v[i].st));
      applyStimulus(v[i]);
      got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL timeout edge %0d: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reversal();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    for (int i = 4; i < 7; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 2));
    for (int i = 7; i < 11; i++) v.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    for (int i = 11; i < 14; i++) v.push_back(mk(0, 0, 1, 0, 0, 0, 3));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(model(v[i].st));
      applyStimulus(v[i]);
      got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL reversal edge %0d: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_idle_rejects();
    vec_t v[$];
    for (int i = 0; i < 3; i++) v.push_back(mk(0, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(model(v[i].st));
      applyStimulus(v[i]);
      got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL idle_rejects edge %0d: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_sensor_fault();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 3));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 3));
    v.push_back(mk(0, 0, 1, 1, 1, 0, 4));
    v.push_back(mk(0, 0, 0, 1, 1, 1, 4));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 1, 0, 1, 1, 0, 4));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    foreach (v[i]) begin
      exp_q.push_back(model(v[i].st));
      applyStimulus(v[i]);
      got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL sensor_fault edge %0d: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    for (int i = 4; i < 12; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 2));
    v.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < 19; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 2));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 2));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 4));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    foreach (v[i]) begin
      exp_q.push_back(model(v[i].st));
      applyStimulus(v[i]);
      got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL reset_mid edge %0d: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 2));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 2));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) v.push_back(mk(0, 0, 1, 1, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 1, 0, 0, 3));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 3));
    v.push_back(mk(0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    foreach (v[i]) begin
      exp_q.push_back(model(v[i].st));
      applyStimulus(v[i]);
      got = {ifc.state, ifc.motor_open, ifc.motor_close, ifc.busy, ifc.fault};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL back_to_back edge %0d: got %b required %b", i, got, exp_v);
      end
    end
  endtask

  initial begin
    ifc.A = 1'b0; ifc.F = 1'b0; ifc.Fd = 1'b0; ifc.Fe = 1'b0; ifc.ack_fault = 1'b0;
    $display("[TB] start");
    test_reset();
    test_open_limit();
    test_timeout();
    test_reversal();
    test_idle_rejects();
    test_sensor_fault();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
